// File: rtl/stopwatch_lap.sv
// stopwatch_lap: BCD stopwatch with lap hold and a multiplexed 7-segment display.
//
// Ports
//   clk, reset                  : system clock, synchronous active-high reset
//   button_start/stop/lap/clear : raw push buttons (high = pressed), asynchronous
//   anode_signals[NUM_DIGITS]   : active-low one-hot digit enable, bit 0 = rightmost digit
//   display_out[6:0]            : active-low segments {g,f,e,d,c,b,a}
//   dp_out                      : active-low decimal point
//   running                     : high while the FSM is in RUNNING
//   lap_active                  : high while the display shows the frozen lap value
//   overflow                    : sticky, set when the count wraps from all 9s
//   state_dbg[1:0]              : FSM state (0 = IDLE, 1 = RUNNING, 2 = STOPPED)
//
// Button events are single-cycle press pulses: a pulse is asserted for exactly one
// clock when the debounced level goes 0->1, and it is consumed by the FSM in that cycle.
module stopwatch_lap #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 100,
  parameter int NUM_DIGITS      = 4,
  parameter int REFRESH_HZ      = 1000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int DP_POS          = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  button_start,
  input  logic                  button_stop,
  input  logic                  button_lap,
  input  logic                  button_clear,
  output logic [NUM_DIGITS-1:0] anode_signals,
  output logic [6:0]            display_out,
  output logic                  dp_out,
  output logic                  running,
  output logic                  lap_active,
  output logic                  overflow,
  output logic [1:0]            state_dbg
);

  localparam int PRESCALE    = CLK_HZ / TICK_HZ;
  localparam int REFRESH_DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW          = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW          = $clog2(NUM_DIGITS);
  localparam int CW          = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE = 2'd0, RUNNING = 2'd1, STOPPED = 2'd2} state_t;

  // ---------------- synchroniser + debouncer, one lane per button ----------------
  // Lane order: 0 = start, 1 = stop, 2 = lap, 3 = clear.
  logic [3:0]    btn_raw;
  logic [3:0]    sync1_q, sync2_q, stable_q, pulse_q;
  logic [DW-1:0] db_cnt_q [4];

  assign btn_raw = {button_clear, button_lap, button_stop, button_start};

  // The counter runs only while the synchronised level differs from the accepted
  // level; any sample equal to the accepted level restarts the qualification.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      pulse_q  <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        pulse_q[i] <= 1'b0;
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable_q[i] <= sync2_q[i];
          pulse_q[i]  <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic start_p, stop_p, lap_p, clear_p;
  assign start_p = pulse_q[0];
  assign stop_p  = pulse_q[1];
  assign lap_p   = pulse_q[2];
  assign clear_p = pulse_q[3];

  // ---------------- control FSM ----------------
  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stop wins over a simultaneous start, so start only acts when stop is absent.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_p && !stop_p) state_d = RUNNING;
      RUNNING: if (stop_p) state_d = STOPPED;
      STOPPED: begin
        if (start_p && !stop_p) state_d = RUNNING;
        else if (clear_p)       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic go_run, enter_stop, do_clear, lap_go;
  assign go_run     = (state_q == IDLE)    && (state_d == RUNNING);
  assign enter_stop = (state_q == RUNNING) && (state_d == STOPPED);
  assign do_clear   = (state_q == STOPPED) && (state_d == IDLE);
  assign lap_go     = (state_q == RUNNING) && (state_d == RUNNING) && lap_p;

  // ---------------- prescaler ----------------
  logic [PW-1:0] presc_q;
  logic          tick;

  assign tick = (state_q == RUNNING) && (presc_q == PW'(PRESCALE - 1));

  // Holds its value through STOPPED so a resumed run keeps its sub-tick phase.
  always_ff @(posedge clk) begin
    if (reset || do_clear || go_run) presc_q <= '0;
    else if (state_q == RUNNING)     presc_q <= tick ? '0 : presc_q + 1'b1;
  end

  // ---------------- BCD counter ----------------
  logic [CW-1:0] count_q, count_inc, lap_q;
  logic          carry;
  logic          overflow_q, lap_active_q;

  // Ripple increment; carry out of the top digit means the count was all 9s.
  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || do_clear) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (tick) begin
      count_q <= count_inc;
      if (carry) overflow_q <= 1'b1;
    end
  end

  // ---------------- lap register ----------------
  always_ff @(posedge clk) begin
    if (reset || do_clear) begin
      lap_q        <= '0;
      lap_active_q <= 1'b0;
    end else if (enter_stop) begin
      lap_active_q <= 1'b0;
    end else if (lap_go) begin
      if (lap_active_q) begin
        lap_active_q <= 1'b0;
      end else begin
        lap_q        <= count_q;
        lap_active_q <= 1'b1;
      end
    end
  end

  // ---------------- display multiplexer ----------------
  logic [CW-1:0] disp_val;
  logic [RW-1:0] ref_q;
  logic [IW-1:0] digit_q;
  logic [3:0]    cur_digit;
  logic [6:0]    seg_d;

  assign disp_val  = lap_active_q ? lap_q : count_q;
  assign cur_digit = disp_val[{digit_q, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_q   <= '0;
      digit_q <= '0;
    end else if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_q   <= '0;
      digit_q <= (digit_q == IW'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  always_comb begin
    seg_d = 7'b1111111;
    case (cur_digit)
      4'd0: seg_d = 7'b1000000;
      4'd1: seg_d = 7'b1111001;
      4'd2: seg_d = 7'b0100100;
      4'd3: seg_d = 7'b0110000;
      4'd4: seg_d = 7'b0011001;
      4'd5: seg_d = 7'b0010010;
      4'd6: seg_d = 7'b0000010;
      4'd7: seg_d = 7'b1111000;
      4'd8: seg_d = 7'b0000000;
      4'd9: seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
  end

  // Anode, segments and dp are all registered from the same digit index, so the
  // three outputs change together one cycle after the index moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode_signals <= ~NUM_DIGITS'(1);
      display_out   <= 7'b1000000;
      dp_out        <= (DP_POS == 0) ? 1'b0 : 1'b1;
    end else begin
      anode_signals <= ~(NUM_DIGITS'(1) << digit_q);
      display_out   <= seg_d;
      dp_out        <= !(int'(digit_q) == DP_POS);
    end
  end

  assign running    = (state_q == RUNNING);
  assign lap_active = lap_active_q;
  assign overflow   = overflow_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// tb_stopwatch_lap: directed stimulus on two stopwatch_lap instances.
// Instance A uses the 4-digit reference setup; instance B is a 2-digit, fast-tick
// build so the all-9s wrap is reachable in a few hundred cycles.
// Each expectation word is {value_checked, state[1:0], overflow, lap_active,
// running, scan_ok, displayed_bcd[15:0]}; the monitor builds the same word from
// one complete display scan frame.
module tb_stopwatch_lap;
  localparam int W = 23;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic [3:0] btn_a, btn_b;  // {clear, lap, stop, start}
  logic [3:0] an_a;
  logic [1:0] an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, run_a, run_b, lap_a, lap_b, ov_a, ov_b;
  logic [1:0] st_a, st_b;

  stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .NUM_DIGITS(4), .REFRESH_HZ(50),
                  .DEBOUNCE_CYCLES(4), .DP_POS(2)) dut_a (
    .clk(clk), .reset(reset),
    .button_start(btn_a[0]), .button_stop(btn_a[1]),
    .button_lap(btn_a[2]), .button_clear(btn_a[3]),
    .anode_signals(an_a), .display_out(seg_a), .dp_out(dp_a),
    .running(run_a), .lap_active(lap_a), .overflow(ov_a), .state_dbg(st_a)
  );

  stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(500), .NUM_DIGITS(2), .REFRESH_HZ(50),
                  .DEBOUNCE_CYCLES(4), .DP_POS(1)) dut_b (
    .clk(clk), .reset(reset),
    .button_start(btn_b[0]), .button_stop(btn_b[1]),
    .button_lap(btn_b[2]), .button_clear(btn_b[3]),
    .anode_signals(an_b), .display_out(seg_b), .dp_out(dp_b),
    .running(run_b), .lap_active(lap_b), .overflow(ov_b), .state_dbg(st_b)
  );

  // Monitor view of whichever instance is under test.
  int         sel = 0;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp, m_run, m_lap, m_ov;
  logic [1:0] m_st;

  always_comb begin
    if (sel == 0) begin
      m_an = an_a; m_seg = seg_a; m_dp = dp_a;
      m_run = run_a; m_lap = lap_a; m_ov = ov_a; m_st = st_a;
    end else begin
      m_an = {2'b11, an_b}; m_seg = seg_b; m_dp = dp_b;
      m_run = run_b; m_lap = lap_b; m_ov = ov_b; m_st = st_b;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic logic [W-1:0] mk(bit chk, logic [1:0] st, bit ov, bit lap,
                                      bit run, logic [15:0] val);
    return {chk, st, ov, lap, run, 1'b1, chk ? val : 16'h0000};
  endfunction

  function automatic logic [3:0] seg2dig(input logic [6:0] s);
    case (s)
      7'b1000000: return 4'd0;
      7'b1111001: return 4'd1;
      7'b0100100: return 4'd2;
      7'b0110000: return 4'd3;
      7'b0011001: return 4'd4;
      7'b0010010: return 4'd5;
      7'b0000010: return 4'd6;
      7'b1111000: return 4'd7;
      7'b0000000: return 4'd8;
      7'b0010000: return 4'd9;
      default:    return 4'hE;
    endcase
  endfunction

  task automatic push(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: for each pending expectation, capture one full scan frame starting at
  // a transition into digit 0, checking dwell length, anode order and dp per digit.
  initial begin : monitor
    logic [W-1:0] e, a;
    logic [15:0]  v;
    logic [3:0]   prev, pat;
    bit           ok;
    int           nd, div, dpp, t, dwell;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q[0];
        nd  = (sel == 0) ? 4 : 2;
        div = (sel == 0) ? 5 : 10;
        dpp = (sel == 0) ? 2 : 1;
        ok  = 1'b1;
        v   = 16'h0000;
        prev = m_an;
        t = 0;
        @(negedge clk);
        while (!(m_an == 4'b1110 && prev != 4'b1110) && t < 200) begin
          prev = m_an;
          @(negedge clk);
          t++;
        end
        if (t >= 200) ok = 1'b0;
        for (int d = 0; d < nd; d++) begin
          pat = ~(4'b0001 << d);
          if (m_an != pat) ok = 1'b0;
          v[4*d +: 4] = seg2dig(m_seg);
          dwell = 0;
          while (m_an == pat && dwell < 50) begin
            if (m_dp != ((d == dpp) ? 1'b0 : 1'b1)) ok = 1'b0;
            dwell++;
            @(negedge clk);
          end
          if (dwell != div) ok = 1'b0;
        end
        if (m_an != 4'b1110) ok = 1'b0;
        a = {e[22], m_st, m_ov, m_lap, m_run, ok, e[22] ? v : 16'h0000};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got %h required %h", name_q[0], a, e);
        end
        void'(exp_q.pop_front());
        void'(name_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 600) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: queue depth %0d required 0", exp_q.size());
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int inst, input logic [3:0] m, input int hold);
    if (inst == 0) btn_a = btn_a | m;
    else           btn_b = btn_b | m;
    repeat (hold) @(posedge clk);
    #1;
    if (inst == 0) btn_a = btn_a & ~m;
    else           btn_b = btn_b & ~m;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic bounce_start();
    for (int k = 0; k < 3; k++) begin
      btn_a[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      btn_a[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int c0;
    reset = 1'b1;
    btn_a = 4'b0000;
    btn_b = 4'b0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    push("reset_state", mk(1, S_IDLE, 0, 0, 0, 16'h0000)); drain();

    bounce_start();
    repeat (10) @(posedge clk);
    #1;
    push("bounce_no_start", mk(1, S_IDLE, 0, 0, 0, 16'h0000)); drain();

    // Start, stop 120 cycles later: count ticks land on the stop edge -> 0012.
    c0 = cyc;
    press(0, 4'b0001, 8);
    push("running_flag", mk(0, S_RUN, 0, 0, 1, 16'h0000)); drain();
    wait_to(c0 + 120);
    press(0, 4'b0010, 8);
    push("stop_0012", mk(1, S_STOP, 0, 0, 0, 16'h0012)); drain();
    repeat (50) @(posedge clk);
    #1;
    push("hold_0012", mk(1, S_STOP, 0, 0, 0, 16'h0012)); drain();
    press(0, 4'b0100, 8);
    push("lap_ignored_stopped", mk(1, S_STOP, 0, 0, 0, 16'h0012)); drain();
    press(0, 4'b1000, 8);
    push("clear_to_idle", mk(1, S_IDLE, 0, 0, 0, 16'h0000)); drain();

    // Lap at count 5, live count runs on; second lap releases; stop at 0030.
    c0 = cyc;
    press(0, 4'b0001, 8);
    wait_to(c0 + 55);
    press(0, 4'b0100, 8);
    push("lap_frozen_0005", mk(1, S_RUN, 0, 1, 1, 16'h0005)); drain();
    wait_to(c0 + 160);
    push("lap_hold_live_15", mk(1, S_RUN, 0, 1, 1, 16'h0005)); drain();
    wait_to(c0 + 215);
    press(0, 4'b0100, 8);
    push("lap_release", mk(0, S_RUN, 0, 0, 1, 16'h0000)); drain();
    wait_to(c0 + 300);
    press(0, 4'b0010, 8);
    push("live_stop_0030", mk(1, S_STOP, 0, 0, 0, 16'h0030)); drain();

    // Resume, lap, then start+stop together: stop wins and lap_active drops.
    press(0, 4'b0001, 8);
    push("resume_from_stopped", mk(0, S_RUN, 0, 0, 1, 16'h0000)); drain();
    press(0, 4'b0100, 8);
    push("lap_again", mk(0, S_RUN, 0, 1, 1, 16'h0000)); drain();
    press(0, 4'b0011, 8);
    push("start_stop_same_cycle", mk(0, S_STOP, 0, 0, 0, 16'h0000)); drain();

    // Reset while running and while the stop button is mid-debounce.
    press(0, 4'b0001, 8);
    btn_a[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 btn_a[1] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    push("reset_mid_run", mk(1, S_IDLE, 0, 0, 0, 16'h0000)); drain();

    // Instance B: one tick per 2 cycles, wrap after 100 ticks, stop at 102 -> 02.
    sel = 1;
    c0 = cyc;
    press(1, 4'b0001, 8);
    push("b_run_no_overflow", mk(0, S_RUN, 0, 0, 1, 16'h0000)); drain();
    wait_to(c0 + 204);
    press(1, 4'b0010, 8);
    push("b_wrap_overflow", mk(1, S_STOP, 1, 0, 0, 16'h0002)); drain();
    press(1, 4'b1000, 8);
    push("b_clear", mk(1, S_IDLE, 0, 0, 0, 16'h0000)); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
